conv_phase_sequencer: RTL and testbench
=======================================

// Module: conv_phase_sequencer
// PURPOSE
//  Sequences the convolution datapath through its phases: MEMORY -> SINGLE PE -> SA3x3 -> SA2x2 -> DISPLAY.
//  Drives one level enable per submodule. Enable low holds that submodule in reset.
//  Waits for each submodule's done, inserts an all-idle settle gap between phases, and enforces a per-phase timeout.
//  Records per-phase cycle counts and supports skip, abort and restart.
//  Sits at the top level in place of the free-running mode counter; its enables feed each submodule's rst pin.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max enabled cycles per phase before error; 0 = timeout disabled
//  SETTLE_CYCLES   2     all-enables-low cycles between phases (min 1)
//  CNT_W           16    width of phase cycle counter / phase_cycles
// PORTS
//  clk              in   1      clock
//  rst              in   1      synchronous reset, active-low
//  start            in   1      pulse: begin sequence (IDLE/DISPLAY/ERR only)
//  abort            in   1      pulse: stop immediately, return to IDLE
//  skip_mask        in   3      [0]=skip SINGLE, [1]=skip SA3x3, [2]=skip SA2x2; sampled on accepted start
//  done_memory      in   1      memory phase complete
//  done_single      in   1      single-PE phase complete
//  done_3_3         in   1      3x3 array phase complete
//  done_2_2         in   1      2x2 array phase complete
//  enable_memory    out  1      run memory
//  enable_singlePE  out  1      run single PE
//  enable_SA3x3     out  1      run 3x3 systolic array
//  enable_SA2x2     out  1      run 2x2 systolic array
//  enable_display   out  1      run display
//  mode_num         out  3      0..4 = active/last phase, 5 = GAP, 6 = ERR, 7 = IDLE
//  busy             out  1      high in phases 0-3 and GAP
//  error            out  1      sticky timeout flag
//  err_phase        out  3      phase that timed out
//  phase_cycles     out  CNT_W  enabled-cycle count of the last completed phase
// BEHAVIOUR
//  - All outputs registered.
//  - Reset (rst==0 at posedge): all enables 0, mode_num=7, busy=0, error=0, err_phase=0, phase_cycles=0.
//  - Reset mid-operation aborts without residue.
//  - States: IDLE, RUN(p), GAP, DISPLAY, ERR. At most one enable high in any cycle.
//  - IDLE + start: next cycle RUN(0), enable_memory=1, busy=1, error cleared, skip_mask latched.
//  - RUN(p): enable_p=1. The counter is 1 on the first enabled cycle and increments each cycle.
//    - Only done_p is observed; done from any other phase is ignored.
//    - done_p=1 seen at posedge: phase_cycles<=counter, enable_p<=0, enter GAP for exactly SETTLE_CYCLES cycles.
//  - GAP exit: go to next phase in order, skipping phases whose latched skip bit is set.
//    - MEMORY and DISPLAY are never skipped.
//    - mode_num shows 5 during GAP.
//  - DISPLAY: enable_display=1 and busy=0 indefinitely. start -> GAP, then RUN(0) (full rerun).
//  - Timeout: TIMEOUT_CYCLES != 0 and counter==TIMEOUT_CYCLES with done_p low.
//    - Next cycle: ERR, all enables 0, error=1, err_phase=p, busy=0.
//    - done_p high in that same cycle wins over timeout.
//  - ERR: held until start (restart at RUN(0), error cleared) or reset.
//  - Counter saturates at 2^CNT_W-1 and never wraps.
//  - abort (any state except IDLE): next cycle IDLE, all enables 0, phase_cycles unchanged.
//    - abort beats a same-cycle done or start.
//  - start while busy is ignored. start and abort in IDLE together: stay IDLE.
//  - skip_mask changes mid-sequence have no effect until the next accepted start.
// TESTING
//  1. rst=0 for 2 cycles with start=1 -> all reset values; stays IDLE, mode_num=7.
//  2. skip_mask=0, start; each done_x pulsed 5 cycles after its enable rises.
//     -> enables in order, each followed by 2-cycle all-low gap;
//     -> phase_cycles=5 after each; ends enable_display=1, mode_num=4, busy=0.
//  3. skip_mask=3'b011, start -> enable_memory, gap, then enable_SA2x2 directly; SINGLE and SA3x3 never enabled.
//  4. TIMEOUT_CYCLES=16, done_single never asserted -> ERR on the cycle after the 16th enabled cycle;
//     error=1, err_phase=1, all enables 0; start then restarts at memory with error=0.
//  5. In RUN(2): done_3_3 and abort same cycle -> IDLE, phase_cycles unchanged.
//     In RUN(1): stray done_2_2 ignored.
//  6. rst=0 mid RUN(3) -> reset values next cycle; start in DISPLAY -> 2-cycle gap, then enable_memory=1.

Source files
------------

// File: rtl/conv_phase_sequencer.sv
// Steps the convolution datapath MEMORY -> SINGLE PE -> SA3x3 -> SA2x2 -> DISPLAY with settle gaps,
// per-phase timeout, skip/abort/restart; every output is registered and enables double as submodule resets.
module conv_phase_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       skip_mask,
    input  logic             done_memory,
    input  logic             done_single,
    input  logic             done_3_3,
    input  logic             done_2_2,
    output logic             enable_memory,
    output logic             enable_singlePE,
    output logic             enable_SA3x3,
    output logic             enable_SA2x2,
    output logic             enable_display,
    output logic [2:0]       mode_num,
    output logic             busy,
    output logic             error,
    output logic [2:0]       err_phase,
    output logic [CNT_W-1:0] phase_cycles
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DISPLAY, S_ERR} state_t;

    localparam int unsigned      GAP_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [2:0]       MODE_DISP  = 3'd4;
    localparam logic [2:0]       MODE_GAP   = 3'd5;
    localparam logic [2:0]       MODE_ERR   = 3'd6;
    localparam logic [2:0]       MODE_IDLE  = 3'd7;

    state_t             state_q;
    logic [2:0]         phase_q;
    logic [2:0]         nxt_q;
    logic [2:0]         mask_q;
    logic [GAP_W-1:0]   gap_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [4:0]         en_q;
    logic [2:0]         mode_q;
    logic               busy_q;
    logic               error_q;
    logic [2:0]         err_phase_q;
    logic [CNT_W-1:0]   phase_cycles_q;
    logic               done_cur;
    logic               start_ok;

    // First phase after p whose skip bit is clear; DISPLAY (4) when none remain.
    function automatic logic [2:0] next_phase(input logic [2:0] p, input logic [2:0] mask);
        if (p < 3'd1 && !mask[0])      next_phase = 3'd1;
        else if (p < 3'd2 && !mask[1]) next_phase = 3'd2;
        else if (p < 3'd3 && !mask[2]) next_phase = 3'd3;
        else                           next_phase = 3'd4;
    endfunction

    always_comb begin
        done_cur = 1'b0;
        case (phase_q)
            3'd0:    done_cur = done_memory;
            3'd1:    done_cur = done_single;
            3'd2:    done_cur = done_3_3;
            3'd3:    done_cur = done_2_2;
            default: done_cur = 1'b0;
        endcase
    end

    assign cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign start_ok = start & ~abort;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            phase_q        <= 3'd0;
            nxt_q          <= 3'd0;
            mask_q         <= 3'd0;
            gap_q          <= '0;
            cnt_q          <= '0;
            en_q           <= 5'd0;
            mode_q         <= MODE_IDLE;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
            err_phase_q    <= 3'd0;
            phase_cycles_q <= '0;
        end else if (abort && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            en_q    <= 5'd0;
            mode_q  <= MODE_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start_ok) begin
                        mask_q  <= skip_mask;
                        error_q <= 1'b0;
                        state_q <= S_RUN;
                        phase_q <= 3'd0;
                        cnt_q   <= CNT_W'(1);
                        en_q    <= 5'b00001;
                        mode_q  <= 3'd0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    // A done sampled on the timeout cycle still completes the phase.
                    if (done_cur) begin
                        phase_cycles_q <= cnt_q;
                        en_q           <= 5'd0;
                        state_q        <= S_GAP;
                        gap_q          <= '0;
                        nxt_q          <= next_phase(phase_q, mask_q);
                        mode_q         <= MODE_GAP;
                    end else if (TIMEOUT_EN && cnt_q == TIMEOUT_V) begin
                        state_q     <= S_ERR;
                        en_q        <= 5'd0;
                        error_q     <= 1'b1;
                        err_phase_q <= phase_q;
                        busy_q      <= 1'b0;
                        mode_q      <= MODE_ERR;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        phase_q <= nxt_q;
                        en_q    <= 5'(5'b00001 << nxt_q);
                        mode_q  <= nxt_q;
                        if (nxt_q == MODE_DISP) begin
                            state_q <= S_DISPLAY;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_RUN;
                            cnt_q   <= CNT_W'(1);
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                S_DISPLAY: begin
                    // Rerun goes through a settle gap so the display drops before memory restarts.
                    if (start_ok) begin
                        mask_q  <= skip_mask;
                        error_q <= 1'b0;
                        state_q <= S_GAP;
                        gap_q   <= '0;
                        nxt_q   <= 3'd0;
                        en_q    <= 5'd0;
                        mode_q  <= MODE_GAP;
                        busy_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign enable_memory   = en_q[0];
    assign enable_singlePE = en_q[1];
    assign enable_SA3x3    = en_q[2];
    assign enable_SA2x2    = en_q[3];
    assign enable_display  = en_q[4];
    assign mode_num        = mode_q;
    assign busy            = busy_q;
    assign error           = error_q;
    assign err_phase       = err_phase_q;
    assign phase_cycles    = phase_cycles_q;

endmodule

// File: tb/tb_conv_phase_sequencer.sv
// Bench for conv_phase_sequencer: directed phase sequences, expected output snapshots queued by stimulus.
module tb_conv_phase_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [2:0]  skip_mask;
    logic [3:0]  done_v;
    logic        en_mem, en_sp, en_33, en_22, en_disp;
    logic [2:0]  mode_num, err_phase;
    logic        busy, error;
    logic [15:0] phase_cycles;
    logic [4:0]  en_vec;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0]  en;
        logic [2:0]  mode;
        logic        busy;
        logic        err;
        logic [2:0]  eph;
        logic [15:0] pc;
    } snap_t;

    typedef struct {
        snap_t s;
        int    hold;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    conv_phase_sequencer #(
        .TIMEOUT_CYCLES(16),
        .SETTLE_CYCLES (2),
        .CNT_W         (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .skip_mask      (skip_mask),
        .done_memory    (done_v[0]),
        .done_single    (done_v[1]),
        .done_3_3       (done_v[2]),
        .done_2_2       (done_v[3]),
        .enable_memory  (en_mem),
        .enable_singlePE(en_sp),
        .enable_SA3x3   (en_33),
        .enable_SA2x2   (en_22),
        .enable_display (en_disp),
        .mode_num       (mode_num),
        .busy           (busy),
        .error          (error),
        .err_phase      (err_phase),
        .phase_cycles   (phase_cycles)
    );

    always #5 clk = ~clk;

    assign en_vec = {en_disp, en_22, en_33, en_sp, en_mem};

    // hold = number of cycles the previous snapshot must have lasted (0 = not checked)
    task automatic expect_snap(input string tag, input logic [4:0] en, input logic [2:0] mode,
                               input logic b, input logic e, input logic [2:0] eph,
                               input logic [15:0] pc, input int hold);
        exp_t x;
        x.s    = '{en: en, mode: mode, busy: b, err: e, eph: eph, pc: pc};
        x.hold = hold;
        x.tag  = tag;
        exp_q.push_back(x);
    endtask

    // Monitor: every change of the output vector consumes one expected snapshot.
    initial begin
        snap_t last;
        snap_t cur;
        exp_t  x;
        int    hold;
        last = 'x;
        hold = 0;
        forever begin
            @(negedge clk);
            cur = '{en: en_vec, mode: mode_num, busy: busy, err: error, eph: err_phase, pc: phase_cycles};
            if (cur !== last) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got en=%b mode=%0d busy=%b err=%b eph=%0d pc=%0d, none expected",
                             cur.en, cur.mode, cur.busy, cur.err, cur.eph, cur.pc);
                end else begin
                    x = exp_q.pop_front();
                    if (cur !== x.s) begin
                        n_fail++;
                        $display("FAIL %s: got en=%b mode=%0d busy=%b err=%b eph=%0d pc=%0d, want en=%b mode=%0d busy=%b err=%b eph=%0d pc=%0d",
                                 x.tag, cur.en, cur.mode, cur.busy, cur.err, cur.eph, cur.pc,
                                 x.s.en, x.s.mode, x.s.busy, x.s.err, x.s.eph, x.s.pc);
                    end
                    if (x.hold != 0) begin
                        n_checks++;
                        if (hold != x.hold) begin
                            n_fail++;
                            $display("FAIL %s_prev_duration: got %0d cycles, want %0d", x.tag, hold, x.hold);
                        end
                    end
                end
                last = cur;
                hold = 1;
            end else begin
                hold++;
            end
        end
    end

    task automatic pulse_start(input logic [2:0] m);
        @(negedge clk);
        start     = 1'b1;
        skip_mask = m;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Returns on the first negedge where the enable is seen high (enabled cycle 1).
    task automatic wait_en(input logic [2:0] idx);
        int n;
        n = 0;
        while (!en_vec[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!en_vec[idx]) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_enable%0d: got enable=0 after %0d cycles, want 1", idx, n);
        end
    endtask

    // done sampled on enabled cycle d, so phase_cycles should read d.
    task automatic pulse_done(input logic [2:0] idx, input int d);
        wait_en(idx);
        repeat (d - 1) @(negedge clk);
        done_v = 4'b0001 << idx;
        @(negedge clk);
        done_v = 4'b0000;
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b1; abort = 1'b0; skip_mask = 3'b000; done_v = 4'b0000;

        // 1: reset with start held high
        expect_snap("reset", 5'b00000, 3'd7, 0, 0, 3'd0, 16'd0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        repeat (4) @(negedge clk);

        // 2: full sequence, every phase 5 cycles
        expect_snap("t2_mem",   5'b00001, 3'd0, 1, 0, 3'd0, 16'd0, 0);
        expect_snap("t2_gap0",  5'b00000, 3'd5, 1, 0, 3'd0, 16'd5, 5);
        expect_snap("t2_sp",    5'b00010, 3'd1, 1, 0, 3'd0, 16'd5, 2);
        expect_snap("t2_gap1",  5'b00000, 3'd5, 1, 0, 3'd0, 16'd5, 5);
        expect_snap("t2_sa33",  5'b00100, 3'd2, 1, 0, 3'd0, 16'd5, 2);
        expect_snap("t2_gap2",  5'b00000, 3'd5, 1, 0, 3'd0, 16'd5, 5);
        expect_snap("t2_sa22",  5'b01000, 3'd3, 1, 0, 3'd0, 16'd5, 2);
        expect_snap("t2_gap3",  5'b00000, 3'd5, 1, 0, 3'd0, 16'd5, 5);
        expect_snap("t2_disp",  5'b10000, 3'd4, 0, 0, 3'd0, 16'd5, 2);
        pulse_start(3'b000);
        pulse_done(3'd0, 5);
        pulse_done(3'd1, 5);
        pulse_done(3'd2, 5);
        pulse_done(3'd3, 5);
        wait_en(3'd4);
        repeat (3) @(negedge clk);

        // 3: rerun from DISPLAY skipping SINGLE and SA3x3; mid-run mask change ignored
        expect_snap("t3_gapS",  5'b00000, 3'd5, 1, 0, 3'd0, 16'd5, 0);
        expect_snap("t3_mem",   5'b00001, 3'd0, 1, 0, 3'd0, 16'd5, 2);
        expect_snap("t3_gap0",  5'b00000, 3'd5, 1, 0, 3'd0, 16'd3, 3);
        expect_snap("t3_sa22",  5'b01000, 3'd3, 1, 0, 3'd0, 16'd3, 2);
        expect_snap("t3_gap3",  5'b00000, 3'd5, 1, 0, 3'd0, 16'd7, 7);
        expect_snap("t3_disp",  5'b10000, 3'd4, 0, 0, 3'd0, 16'd7, 2);
        pulse_start(3'b011);
        skip_mask = 3'b000;
        pulse_done(3'd0, 3);
        pulse_done(3'd3, 7);
        wait_en(3'd4);
        repeat (3) @(negedge clk);

        // 4: SINGLE never completes -> timeout after 16 cycles; stray dones ignored; restart
        expect_snap("t4_gapS",  5'b00000, 3'd5, 1, 0, 3'd0, 16'd7, 0);
        expect_snap("t4_mem",   5'b00001, 3'd0, 1, 0, 3'd0, 16'd7, 2);
        expect_snap("t4_gap0",  5'b00000, 3'd5, 1, 0, 3'd0, 16'd4, 4);
        expect_snap("t4_sp",    5'b00010, 3'd1, 1, 0, 3'd0, 16'd4, 2);
        expect_snap("t4_err",   5'b00000, 3'd6, 0, 1, 3'd1, 16'd4, 16);
        pulse_start(3'b000);
        pulse_done(3'd0, 4);
        wait_en(3'd1);
        repeat (3) @(negedge clk);
        done_v = 4'b1000;
        @(negedge clk);
        done_v = 4'b0101;
        @(negedge clk);
        done_v = 4'b0000;
        n = 0;
        while (!error && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);

        // 5: restart from ERR, then abort with same-cycle done in SA3x3
        expect_snap("t5_mem",   5'b00001, 3'd0, 1, 0, 3'd1, 16'd4, 0);
        expect_snap("t5_gap0",  5'b00000, 3'd5, 1, 0, 3'd1, 16'd5, 5);
        expect_snap("t5_sp",    5'b00010, 3'd1, 1, 0, 3'd1, 16'd5, 2);
        expect_snap("t5_gap1",  5'b00000, 3'd5, 1, 0, 3'd1, 16'd6, 6);
        expect_snap("t5_sa33",  5'b00100, 3'd2, 1, 0, 3'd1, 16'd6, 2);
        expect_snap("t5_abort", 5'b00000, 3'd7, 0, 0, 3'd1, 16'd6, 3);
        pulse_start(3'b000);
        pulse_done(3'd0, 5);
        pulse_done(3'd1, 6);
        wait_en(3'd2);
        repeat (2) @(negedge clk);
        done_v = 4'b0100;
        abort  = 1'b1;
        @(negedge clk);
        done_v = 4'b0000;
        abort  = 1'b0;
        repeat (2) @(negedge clk);

        // 6: start+abort in IDLE stays put; start while busy ignored; reset in SA2x2
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        expect_snap("t6_mem",   5'b00001, 3'd0, 1, 0, 3'd1, 16'd6, 0);
        expect_snap("t6_gap0",  5'b00000, 3'd5, 1, 0, 3'd1, 16'd3, 3);
        expect_snap("t6_sp",    5'b00010, 3'd1, 1, 0, 3'd1, 16'd3, 2);
        expect_snap("t6_gap1",  5'b00000, 3'd5, 1, 0, 3'd1, 16'd2, 2);
        expect_snap("t6_sa33",  5'b00100, 3'd2, 1, 0, 3'd1, 16'd2, 2);
        expect_snap("t6_gap2",  5'b00000, 3'd5, 1, 0, 3'd1, 16'd2, 2);
        expect_snap("t6_sa22",  5'b01000, 3'd3, 1, 0, 3'd1, 16'd2, 2);
        expect_snap("t6_rst",   5'b00000, 3'd7, 0, 0, 3'd0, 16'd0, 3);
        pulse_start(3'b000);
        wait_en(3'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        done_v = 4'b0001;
        @(negedge clk);
        done_v = 4'b0000;
        pulse_done(3'd1, 2);
        pulse_done(3'd2, 2);
        wait_en(3'd3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // all middle phases skipped, then start in DISPLAY -> gap -> memory, then abort
        expect_snap("t6b_mem",  5'b00001, 3'd0, 1, 0, 3'd0, 16'd0, 0);
        expect_snap("t6b_gap0", 5'b00000, 3'd5, 1, 0, 3'd0, 16'd2, 2);
        expect_snap("t6b_disp", 5'b10000, 3'd4, 0, 0, 3'd0, 16'd2, 2);
        expect_snap("t6b_gapS", 5'b00000, 3'd5, 1, 0, 3'd0, 16'd2, 0);
        expect_snap("t6b_mem2", 5'b00001, 3'd0, 1, 0, 3'd0, 16'd2, 2);
        expect_snap("t6b_idle", 5'b00000, 3'd7, 0, 0, 3'd0, 16'd2, 2);
        pulse_start(3'b111);
        pulse_done(3'd0, 2);
        wait_en(3'd4);
        repeat (3) @(negedge clk);
        pulse_start(3'b111);
        wait_en(3'd0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (5) @(negedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations: got %0d pending, want 0 (next %s)", exp_q.size(), exp_q[0].tag);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
